// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer and its bench.
package debounce_pkg;

  localparam logic ACTIVE_HIGH = 1'b1;
  localparam logic ACTIVE_LOW  = 1'b0;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2
  } event_e;

  // Consecutive stable cycles needed before a new level is accepted.
  function automatic int unsigned accept_cycles(input int unsigned ctr_bits);
    return 32'd1 << ctr_bits;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button bus between the debouncer and its consumer. The release event is
// named "released" because "release" is a reserved word in SystemVerilog.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] released;
  logic [CHANNELS-1:0] long_press;

  modport master (
    output btn,
    input  out,
    input  press,
    input  released,
    input  long_press
  );

  modport slave (
    input  btn,
    output out,
    output press,
    output released,
    output long_press
  );

endinterface

// File: rtl/debounce_chan.sv
// One debounced channel: synchroniser, stability counter, edge events and
// long-press detection. Channels share no state.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   CTR_BITS     = 20,
  parameter int   LONG_BITS    = 25,
  parameter int   SYNC_STAGES  = 2,
  parameter logic ACTIVE_LEVEL = ACTIVE_HIGH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic out,
  output logic press,
  output logic released,
  output logic long_press
);

  localparam logic                 INACTIVE = ~ACTIVE_LEVEL;
  localparam logic [CTR_BITS-1:0]  CNT_MAX  = {CTR_BITS{1'b1}};
  localparam logic [LONG_BITS-1:0] HOLD_MAX = {LONG_BITS{1'b1}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   level_s;
  logic [CTR_BITS-1:0]    cnt_r;
  logic [CTR_BITS-1:0]    cnt_s;
  logic                   out_r;
  logic                   out_s;
  logic                   out_q_r;
  logic                   press_r;
  logic                   release_r;
  logic                   long_r;
  logic [LONG_BITS-1:0]   hold_r;
  logic [LONG_BITS-1:0]   hold_s;
  logic                   long_done_r;
  logic                   long_done_s;
  logic                   hit_r;
  logic                   hit_s;

  // Bring the raw input into clk; flops idle at the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{INACTIVE}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  assign level_s = sync_r[SYNC_STAGES-1] ^ INACTIVE;

  // Next-state for the stability counter and the hold/long-press tracker.
  always_comb begin
    cnt_s       = cnt_r;
    out_s       = out_r;
    hold_s      = hold_r;
    long_done_s = long_done_r;
    hit_s       = 1'b0;

    if (level_s == out_r) begin
      cnt_s = {CTR_BITS{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      out_s = level_s;
      cnt_s = {CTR_BITS{1'b0}};
    end else begin
      cnt_s = cnt_r + {{(CTR_BITS-1){1'b0}}, 1'b1};
    end

    if (!out_r) begin
      hold_s      = {LONG_BITS{1'b0}};
      long_done_s = 1'b0;
    end else if (!long_done_r) begin
      if (hold_r == HOLD_MAX) begin
        long_done_s = 1'b1;
        hit_s       = 1'b1;
      end else begin
        hold_s = hold_r + {{(LONG_BITS-1){1'b0}}, 1'b1};
      end
    end else begin
      hold_s = hold_r;
    end
  end

  // State and registered event pulses; a hit is dropped if out fell meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CTR_BITS{1'b0}};
      out_r       <= 1'b0;
      out_q_r     <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      long_r      <= 1'b0;
      hold_r      <= {LONG_BITS{1'b0}};
      long_done_r <= 1'b0;
      hit_r       <= 1'b0;
    end else begin
      cnt_r       <= cnt_s;
      out_r       <= out_s;
      out_q_r     <= out_r;
      press_r     <= out_r & ~out_q_r;
      release_r   <= ~out_r & out_q_r;
      long_r      <= hit_r & out_r;
      hold_r      <= hold_s;
      long_done_r <= long_done_s;
      hit_r       <= hit_s;
    end
  end

  assign out        = out_r;
  assign press      = press_r;
  assign released   = release_r;
  assign long_press = long_r;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: an array of independent debounce_chan instances.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   CHANNELS     = 4,
  parameter int   CTR_BITS     = 20,
  parameter int   LONG_BITS    = 25,
  parameter int   SYNC_STAGES  = 2,
  parameter logic ACTIVE_LEVEL = ACTIVE_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  debounce_multi_if.slave  bus
);

  wire [CHANNELS-1:0] out_s;
  wire [CHANNELS-1:0] press_s;
  wire [CHANNELS-1:0] release_s;
  wire [CHANNELS-1:0] long_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .CTR_BITS     (CTR_BITS),
      .LONG_BITS    (LONG_BITS),
      .SYNC_STAGES  (SYNC_STAGES),
      .ACTIVE_LEVEL (ACTIVE_LEVEL)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn        (bus.btn[i]),
      .out        (out_s[i]),
      .press      (press_s[i]),
      .released   (release_s[i]),
      .long_press (long_s[i])
    );
  end

  assign bus.out        = out_s;
  assign bus.press      = press_s;
  assign bus.released   = release_s;
  assign bus.long_press = long_s;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench: one active-high and one active-low debouncer side by side.
module tb_debounce_multi;
  import debounce_pkg::*;

  localparam int CH        = 4;
  localparam int CTR       = 4;
  localparam int LONG      = 6;
  localparam int SYNC      = 2;
  localparam int ACC       = int'(accept_cycles(CTR));
  localparam int LAT       = SYNC + ACC + 1;
  localparam int LONG_LAT  = (1 << LONG) + 1;
  localparam int LONG_FROM = LAT - 1 + LONG_LAT;

  typedef struct {
    int dut;
    int kind;
    int ch;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic prev_out  [2][CH];
  int   last_edge [2][CH];
  int   last_rise [2][CH];
  int   last_fall [2][CH];
  int   press_cyc [2][CH];
  int   long_cnt  [2][CH];

  debounce_multi_if #(.CHANNELS(CH)) bus_h ();
  debounce_multi_if #(.CHANNELS(CH)) bus_l ();

  debounce_multi #(.CHANNELS(CH), .CTR_BITS(CTR), .LONG_BITS(LONG),
                   .SYNC_STAGES(SYNC), .ACTIVE_LEVEL(ACTIVE_HIGH))
    dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h.slave));

  debounce_multi #(.CHANNELS(CH), .CTR_BITS(CTR), .LONG_BITS(LONG),
                   .SYNC_STAGES(SYNC), .ACTIVE_LEVEL(ACTIVE_LOW))
    dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l.slave));

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int k, input int c, input int t);
    exp_t e;
    e.dut = d; e.kind = k; e.ch = c; e.t = t;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int d, input int k, input int c);
    exp_t e;
    int   code;
    code = d * 100 + k * 10 + c;
    if (sb.size() == 0) begin
      chk("unexpected_event", code + 1, 0);
    end else begin
      e = sb.pop_front();
      chk("event_id", code, e.dut * 100 + e.kind * 10 + e.ch);
      chk("event_time", (cyc >= e.t - 1 && cyc <= e.t + 1) ? e.t : cyc, e.t);
      case (k)
        0: begin
          chk("press_after_out", cyc - last_rise[d][c], 1);
          press_cyc[d][c] = cyc;
        end
        1: chk("release_after_out", cyc - last_fall[d][c], 1);
        default: begin
          chk("long_after_out", cyc - last_rise[d][c], LONG_LAT);
          long_cnt[d][c]++;
        end
      endcase
    end
  endtask

  task automatic monitor_step();
    logic       o;
    logic [2:0] ev;
    int         sp;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (!rst_n) begin
          prev_out[d][c]  = 1'b0;
          last_edge[d][c] = -1;
        end else begin
          o  = (d == 0) ? bus_h.out[c] : bus_l.out[c];
          ev = (d == 0) ? {bus_h.long_press[c], bus_h.released[c], bus_h.press[c]}
                        : {bus_l.long_press[c], bus_l.released[c], bus_l.press[c]};
          if (o !== prev_out[d][c]) begin
            if (last_edge[d][c] >= 0) begin
              sp = cyc - last_edge[d][c];
              chk("min_spacing", (sp < ACC) ? sp : ACC, ACC);
            end
            last_edge[d][c] = cyc;
            if (o) last_rise[d][c] = cyc;
            else   last_fall[d][c] = cyc;
            prev_out[d][c] = o;
          end
          for (int k = 0; k < 3; k++) begin
            if (ev[k]) sb_check(d, k, c);
          end
        end
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int long_before;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        long_cnt[d][c]  = 0;
        press_cyc[d][c] = -1;
        last_rise[d][c] = 0;
        last_fall[d][c] = 0;
      end
    end

    // Reset values with all buttons held pressed
    rst_n = 1'b0;
    bus_h.btn = 4'hF;
    bus_l.btn = 4'hF;
    repeat (3) begin
      tick(1);
      chk("rst_out", bus_h.out, 0);
      chk("rst_press", bus_h.press, 0);
      chk("rst_release", bus_h.released, 0);
      chk("rst_long", bus_h.long_press, 0);
      chk("rst_out_low_pol", bus_l.out, 0);
    end
    rst_n = 1'b1;
    n = cyc;
    for (int c = 0; c < CH; c++) push(0, EV_PRESS, c, n + LAT);
    for (int c = 0; c < CH; c++) push(0, EV_LONG, c, n + LONG_FROM);
    tick(100);
    chk("held_out_all", bus_h.out, 4'hF);
    bus_h.btn = 4'h0;
    n = cyc;
    for (int c = 0; c < CH; c++) push(0, EV_RELEASE, c, n + LAT);
    tick(30);
    chk("sb_empty_reset", sb.size(), 0);

    // Bounce rejection on ch0: every pulse shorter than the accept window
    for (int i = 0; i < 30; i++) begin
      bus_h.btn[0] = 1'b1;
      tick($urandom_range(15, 1));
      bus_h.btn[0] = 1'b0;
      tick($urandom_range(15, 1));
    end
    chk("bounce_out0", bus_h.out[0], 0);
    bus_h.btn[0] = 1'b1;
    n = cyc;
    push(0, EV_PRESS, 0, n + LAT);
    push(0, EV_LONG, 0, n + LONG_FROM);
    tick(120);

    // Release with 10 cycles of bounce, ending low
    for (int i = 0; i < 11; i++) begin
      bus_h.btn[0] = ~bus_h.btn[0];
      n = cyc;
      tick(1);
    end
    push(0, EV_RELEASE, 0, n + LAT);
    tick(40);
    chk("release_out0", bus_h.out[0], 0);
    chk("sb_empty_bounce", sb.size(), 0);

    // Long press on ch1: 200-cycle hold fires once, 40-cycle hold never
    long_before = long_cnt[0][1];
    bus_h.btn[1] = 1'b1;
    n = cyc;
    push(0, EV_PRESS, 1, n + LAT);
    push(0, EV_LONG, 1, n + LONG_FROM);
    tick(200);
    bus_h.btn[1] = 1'b0;
    n = cyc;
    push(0, EV_RELEASE, 1, n + LAT);
    tick(40);
    bus_h.btn[1] = 1'b1;
    n = cyc;
    push(0, EV_PRESS, 1, n + LAT);
    tick(40);
    bus_h.btn[1] = 1'b0;
    n = cyc;
    push(0, EV_RELEASE, 1, n + LAT);
    tick(120);
    chk("long_once_ch1", long_cnt[0][1] - long_before, 1);
    chk("sb_empty_long", sb.size(), 0);

    // Active-low polarity, ch2 and ch3 pressed on the same cycle
    bus_l.btn[2] = 1'b0;
    bus_l.btn[3] = 1'b0;
    n = cyc;
    push(1, EV_PRESS, 2, n + LAT);
    push(1, EV_PRESS, 3, n + LAT);
    push(1, EV_LONG, 2, n + LONG_FROM);
    push(1, EV_LONG, 3, n + LONG_FROM);
    tick(100);
    chk("pol_out", bus_l.out, 4'b1100);
    chk("pol_other_dut", bus_h.out, 0);
    chk("pol_same_cycle", press_cyc[1][3], press_cyc[1][2]);
    bus_l.btn = 4'hF;
    n = cyc;
    push(1, EV_RELEASE, 2, n + LAT);
    push(1, EV_RELEASE, 3, n + LAT);
    tick(30);
    chk("sb_empty_polarity", sb.size(), 0);

    // Reset mid-count on ch0 discards progress
    bus_h.btn[0] = 1'b1;
    tick(12);
    chk("mid_cnt_before", dut_h.g_chan[0].u_chan.cnt_r, 10);
    rst_n = 1'b0;
    #1;
    chk("mid_out_rst", bus_h.out, 0);
    chk("mid_cnt_cleared", dut_h.g_chan[0].u_chan.cnt_r, 0);
    tick(3);
    chk("mid_press_rst", bus_h.press, 0);
    rst_n = 1'b1;
    n = cyc;
    push(0, EV_PRESS, 0, n + LAT);
    push(0, EV_LONG, 0, n + LONG_FROM);
    tick(100);
    bus_h.btn[0] = 1'b0;
    n = cyc;
    push(0, EV_RELEASE, 0, n + LAT);
    tick(30);
    chk("sb_empty_midreset", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Multi-channel, parametrised successor to the single-button debouncer. It takes `CHANNELS` raw, asynchronous button or switch inputs of configurable polarity and synchronises each one into `clk`. It filters contact bounce with a per-channel stability counter and presents a clean level per channel. It also emits single-cycle press, release and long-press event pulses, so the MCS GPIO/interrupt logic can consume button events directly without software polling.

## Interface
- `CHANNELS`, 4: number of independent inputs (1..32).
- `CTR_BITS`, 20: stability counter width; a level is accepted after 2^CTR_BITS consecutive stable cycles (20 bits ≈ 21 ms at 50 MHz).
- `LONG_BITS`, 25: hold counter width; long press fires after 2^LONG_BITS cycles of debounced active level (≈ 0.67 s at 50 MHz).
- `SYNC_STAGES`, 2: synchroniser depth (≥ 2).
- `ACTIVE_LEVEL`, 1'b1: raw `btn` level meaning "pressed".
- `clk` input 1: sole clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn` input CHANNELS: raw asynchronous inputs.
- `out` output CHANNELS: debounced state; 1 = pressed, independent of `ACTIVE_LEVEL`.
- `press` output CHANNELS: one-cycle pulse when `out[i]` goes 0→1.
- `release` output CHANNELS: one-cycle pulse when `out[i]` goes 1→0.
- `long_press` output CHANNELS: one-cycle pulse, at most once per press, when the hold threshold is reached.

## Operation
- **Reset (`rst_n` = 0, asynchronous)**:
  - all synchroniser flops load the inactive level (~`ACTIVE_LEVEL`);
  - `out`, `press`, `release` and `long_press` all go to 0;
  - all counters clear and all `long_done` flags clear.
- **Synchronisation**: `s[i]` = final synchroniser stage XOR ~`ACTIVE_LEVEL`, i.e. normalised so that 1 = pressed.
- **Debounce, per channel**, using counter `cnt` of `CTR_BITS` bits:
  - if `s == out`: `cnt` <= 0;
  - else if `cnt == 2^CTR_BITS-1`: `out` <= `s` and `cnt` <= 0;
  - else: `cnt` <= `cnt` + 1.
  - Any single cycle of `s == out` restarts the count, so glitches shorter than 2^CTR_BITS cycles never reach `out`.
- **Events**: `press` = `out` & ~`out_q`; `release` = ~`out` & `out_q`; `out_q` is `out` delayed by one cycle. Pulses are registered and are never wider than one cycle.
- **Long press, per channel**, using counter `hold` of `LONG_BITS` bits plus flag `long_done`:
  - when `out` = 0: `hold` <= 0 and `long_done` <= 0;
  - when `out` = 1 and `long_done` = 0: `hold` increments; when `hold == 2^LONG_BITS-1`, `long_press` pulses next cycle and `long_done` <= 1;
  - when `long_done` = 1: `hold` is frozen and there are no further pulses until release.
  - A release that happens exactly on the threshold cycle suppresses the pulse: the release wins.
- **Channel independence**: channels share no state. Simultaneous transitions on several channels produce simultaneous pulses on each.

## Timing
- **Press latency**: `btn` edge (stable from then on) to `out` rising = SYNC_STAGES + 2^CTR_BITS cycles (±1 for asynchronous input sampling). `press` asserts 1 cycle after `out`.
- **Release latency**: identical to press latency; `release` asserts 1 cycle after `out` falls.
- **Long press**: `long_press` asserts 2^LONG_BITS + 1 cycles after `out` rises, provided `out` stays 1 throughout.
- **Minimum spacing**: at least 2^CTR_BITS cycles between any two `out` edges on one channel.
- **Reset mid-operation**: in-flight counts are discarded. After `rst_n` deasserts, a held button produces `press` only after a full SYNC_STAGES + 2^CTR_BITS cycles.

## Structure
- Shared package `debounce_pkg`: the `ACTIVE_HIGH` / `ACTIVE_LOW` level constants and the function computing cycles-to-accept from `CTR_BITS`, which the bench also uses.
- Sub-module `debounce_chan`: one channel, containing the synchroniser, `cnt`, `out`, `out_q`, event pulses, `hold` and `long_done`. `debounce_multi` is a generate loop of `CHANNELS` instances with no shared logic.

## Test plan
Run with CHANNELS=4, CTR_BITS=4, LONG_BITS=6, SYNC_STAGES=2, 20 ns clock.
- **Reset values**: hold `rst_n` = 0 with `btn` = 4'hF → `out`, `press`, `release` and `long_press` are all 0. Release `rst_n` → `out[i]` rises 18 ±1 cycles later, with `press` 1 cycle after that.
- **Bounce rejection**: drive ch0 with 30 pulses of random width 1–15 cycles → `out[0]` stays 0. Then hold `btn[0]` high → exactly one `press` pulse, and no `out` edges spaced fewer than 16 cycles apart.
- **Release**: drive stable high, then low with 10 cycles of bounce → exactly one `release` pulse 18 ±1 cycles after the last bounce edge.
- **Long press**: hold ch1 for 200 cycles → `long_press[1]` pulses exactly once, 65 cycles after `out[1]` rises. Release at 40 cycles → no `long_press` pulse.
- **Polarity and independence**: with ACTIVE_LEVEL=0, drive `btn` low on ch2 and ch3 on the same cycle → `press[2]` and `press[3]` assert on the same cycle; ch0 and ch1 remain 0.
- **Reset mid-count**: assert `rst_n` = 0 while `cnt` = 10 on ch0 → `out[0]` = 0 immediately. After deassertion, the full 18-cycle latency applies again.
